// File: rtl/rt_pkg.sv
// Shared definitions for the reaction timer: FSM encoding, display saturation
// value and the LFSR seed/taps used for the pseudo-random arm delay.
package rt_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        GO   = 3'd2,
        DONE = 3'd3,
        FOUL = 3'd4
    } state_e;

    localparam int unsigned MAX_COUNT = 9999;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw button to single-cycle press pulse: 2-FF synchroniser, debounce counter,
// and rising-edge detect on the accepted level.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; any agreeing sample restarts the stability window.
    always_comb begin
        sync_d  = {sync_q[0], btn};
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                press_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: arm on press, random delay, GO, measure ms until the next
// press. Flags false starts and saturates at COUNT_MAX as a timeout.
module reaction_timer
    import rt_pkg::*;
#(
    parameter int unsigned TICK_CYCLES     = 100000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned MIN_DELAY_MS    = 1000,
    parameter int unsigned COUNT_MAX       = MAX_COUNT,
    parameter logic [15:0] LFSR_INIT       = LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn,
    output logic [13:0] number,
    output logic        go_led,
    output logic        result_valid,
    output logic        foul,
    output logic        timeout
);

    localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [13:0]   MAX_C     = 14'(COUNT_MAX);

    logic press;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .press(press)
    );

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [11:0]   delay_q, delay_d;
    logic [13:0]   count_q, count_d;
    logic [13:0]   number_q, number_d;
    logic          timeout_q, timeout_d;
    logic          tick;

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        count_d   = count_q;
        number_d  = number_q;
        timeout_d = timeout_q;
        lfsr_d    = lfsr_next(lfsr_q);
        tick      = (presc_q == TICK_LAST);
        presc_d   = tick ? '0 : presc_q + PW'(1);

        unique case (state_q)
            IDLE, DONE, FOUL: begin
                if (press) begin
                    state_d   = WAIT;
                    delay_d   = 12'(MIN_DELAY_MS) + 12'(lfsr_q[10:0]);
                    number_d  = '0;
                    timeout_d = 1'b0;
                end
            end
            WAIT: begin
                // A press always wins over the final delay tick.
                if (press) begin
                    state_d  = FOUL;
                    number_d = '0;
                end else if (tick) begin
                    if (delay_q <= 12'd1) begin
                        state_d  = GO;
                        count_d  = '0;
                        number_d = '0;
                    end else begin
                        delay_d = delay_q - 12'd1;
                    end
                end
            end
            GO: begin
                if (press) begin
                    state_d  = DONE;
                    number_d = count_q;
                end else if (tick) begin
                    if (count_q >= MAX_C - 14'd1) begin
                        state_d   = DONE;
                        count_d   = MAX_C;
                        number_d  = MAX_C;
                        timeout_d = 1'b1;
                    end else begin
                        count_d  = count_q + 14'd1;
                        number_d = count_q + 14'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Every state starts its ms grid from a fresh prescaler phase.
        if (state_d != state_q) presc_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            lfsr_q    <= LFSR_INIT;
            delay_q   <= '0;
            count_q   <= '0;
            number_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            lfsr_q    <= lfsr_d;
            delay_q   <= delay_d;
            count_q   <= count_d;
            number_q  <= number_d;
            timeout_q <= timeout_d;
        end
    end

    assign number       = number_q;
    assign go_led       = (state_q == GO);
    assign result_valid = (state_q == DONE);
    assign foul         = (state_q == FOUL);
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Scoreboard bench for reaction_timer: expected output snapshots are queued
// with their cycle number as stimulus is driven and compared at negedges.
module tb_reaction_timer;

    localparam int unsigned TICK = 10;
    localparam int unsigned DEB  = 4;
    localparam int unsigned MIND = 20;
    localparam int unsigned CMAX = 150;

    // Arming happens 9 LFSR steps after reset release; walk the LFSR back so
    // the state seen at that press has lfsr[10:0] == 5 (delay = 25 ms).
    function automatic logic [15:0] seed_back(input logic [15:0] s, input int n);
        logic [15:0] c = s;
        for (int i = 0; i < n; i++) c = {c[0] ^ c[14] ^ c[13] ^ c[11], c[15:1]};
        return c;
    endfunction
    localparam logic [15:0] SEED = seed_back(16'h0005, 9);

    logic        clk = 1'b0;
    logic        rst;
    logic        btn;
    logic [13:0] number;
    logic        go_led, result_valid, foul, timeout;

    reaction_timer #(
        .TICK_CYCLES(TICK), .DEBOUNCE_CYCLES(DEB), .MIN_DELAY_MS(MIND),
        .COUNT_MAX(CMAX), .LFSR_INIT(SEED)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn), .number(number), .go_led(go_led),
        .result_valid(result_valid), .foul(foul), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ov(input int n, input bit g, input bit rv, input bit fl, input bit to);
        return {14'd0, 14'(n), g, rv, fl, to};
    endfunction

    function automatic logic [31:0] obs();
        return {14'd0, number, go_led, result_valid, foul, timeout};
    endfunction

    typedef struct {
        int unsigned cyc;
        logic [31:0] v;
        string       tag;
    } exp_t;
    exp_t sbq[$];

    task automatic expect_at(input string tag, input int unsigned c, input logic [31:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            chk(e.tag, obs(), e.v);
        end
    end

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    // Reset, then raise btn so the FSM sees press exactly 7 edges later.
    task automatic arm_from_reset(output int unsigned e_wait);
        @(negedge clk);
        rst = 1'b0;
        btn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        btn    = 1'b1;
        e_wait = cyc + 7;
        expect_at("arm_idle", cyc + 6, ov(0, 0, 0, 0, 0));
    endtask

    // Drive a press whose FSM-visible edge is cycle c.
    task automatic press_at(input int unsigned c);
        wait_until(c - 7);
        btn = 1'b1;
    endtask

    int unsigned e, g, ts, b0;

    initial begin
        rst = 1'b1;
        btn = 1'b0;
        #1 rst = 1'b0;
        #1 chk("reset_state", obs(), ov(0, 0, 0, 0, 0));

        // Reset mid-GO.
        arm_from_reset(e);
        g = e + 250;
        expect_at("r_pre_go", g - 1, ov(0, 0, 0, 0, 0));
        expect_at("r_go", g, ov(0, 1, 0, 0, 0));
        expect_at("r_go_cnt", g + 55, ov(5, 1, 0, 0, 0));
        wait_until(e + 10);
        btn = 1'b0;
        wait_until(g + 60);
        #2 rst = 1'b0;
        #1 chk("rst_async", obs(), ov(0, 0, 0, 0, 0));

        // Normal round: 37 ms reaction.
        arm_from_reset(e);
        g = e + 250;
        expect_at("n_wait_end", g - 1, ov(0, 0, 0, 0, 0));
        expect_at("n_go", g, ov(0, 1, 0, 0, 0));
        expect_at("n_go_t0", g + 9, ov(0, 1, 0, 0, 0));
        expect_at("n_go_t1", g + 10, ov(1, 1, 0, 0, 0));
        wait_until(e + 10);
        btn = 1'b0;
        expect_at("n_pre_press", g + 374, ov(37, 1, 0, 0, 0));
        expect_at("n_done", g + 375, ov(37, 0, 1, 0, 0));
        expect_at("n_done_hold", g + 400, ov(37, 0, 1, 0, 0));
        press_at(g + 375);
        wait_until(g + 390);
        btn = 1'b0;
        wait_until(g + 401);

        // False start, then re-arm clears the flag.
        arm_from_reset(e);
        wait_until(e + 10);
        btn = 1'b0;
        expect_at("f_wait", e + 99, ov(0, 0, 0, 0, 0));
        expect_at("f_foul", e + 100, ov(0, 0, 0, 1, 0));
        expect_at("f_hold", e + 199, ov(0, 0, 0, 1, 0));
        expect_at("f_pre_rearm", e + 206, ov(0, 0, 0, 1, 0));
        expect_at("f_rearm", e + 207, ov(0, 0, 0, 0, 0));
        expect_at("f_no_go", e + 357, ov(0, 0, 0, 0, 0));
        press_at(e + 100);
        wait_until(e + 120);
        btn = 1'b0;
        press_at(e + 207);
        wait_until(e + 220);
        btn = 1'b0;
        wait_until(e + 358);

        // Timeout: no press in GO.
        arm_from_reset(e);
        g = e + 250;
        wait_until(e + 10);
        btn = 1'b0;
        expect_at("t_cnt", g + 1490, ov(CMAX - 1, 1, 0, 0, 0));
        expect_at("t_pre_sat", g + 1499, ov(CMAX - 1, 1, 0, 0, 0));
        expect_at("t_sat", g + 1500, ov(CMAX, 0, 1, 0, 1));
        expect_at("t_hold", g + 1600, ov(CMAX, 0, 1, 0, 1));
        wait_until(g + 1601);

        // Press on the final WAIT tick.
        arm_from_reset(e);
        wait_until(e + 10);
        btn = 1'b0;
        expect_at("ca_wait", e + 249, ov(0, 0, 0, 0, 0));
        expect_at("ca_foul", e + 250, ov(0, 0, 0, 1, 0));
        expect_at("ca_hold", e + 300, ov(0, 0, 0, 1, 0));
        press_at(e + 250);
        wait_until(e + 260);
        btn = 1'b0;
        wait_until(e + 301);

        // Press on a GO tick at count 12.
        arm_from_reset(e);
        g = e + 250;
        wait_until(e + 10);
        btn = 1'b0;
        expect_at("cb_pre", g + 129, ov(12, 1, 0, 0, 0));
        expect_at("cb_done", g + 130, ov(12, 0, 1, 0, 0));
        expect_at("cb_hold", g + 140, ov(12, 0, 1, 0, 0));
        press_at(g + 130);
        wait_until(g + 140);
        btn = 1'b0;

        // Bounce from DONE: only the settled edge may arm.
        wait_until(g + 160);
        b0 = cyc;
        expect_at("b_bouncing", b0 + 40, ov(12, 0, 1, 0, 0));
        for (int i = 0; i < 20; i++) begin
            btn = ~i[0];
            repeat (2) @(negedge clk);
        end
        btn = 1'b1;
        ts  = cyc;
        expect_at("b_pre_press", ts + 6, ov(12, 0, 1, 0, 0));
        expect_at("b_armed", ts + 7, ov(0, 0, 0, 0, 0));
        expect_at("b_single", ts + 157, ov(0, 0, 0, 0, 0));
        wait_until(ts + 160);

        chk("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected finish before %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

endmodule
